// File: rtl/dfs_pkg.sv
// Shared definitions for the DFS governor: op_code constants, FSM states and
// the level-to-op_code encoder.
// Ports: none. This is a package.
package dfs_pkg;

  localparam logic [5:0] OP_L0 = 6'b000001;
  localparam logic [5:0] OP_L1 = 6'b000010;
  localparam logic [5:0] OP_L2 = 6'b101010;
  localparam logic [5:0] OP_L3 = 6'b111111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DECIDE  = 2'd2
  } state_t;

  function automatic logic [5:0] lvl_to_op(input logic [1:0] lvl);
    logic [5:0] op;
    case (lvl)
      2'd0:    op = OP_L0;
      2'd1:    op = OP_L1;
      2'd2:    op = OP_L2;
      default: op = OP_L3;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/activity_window.sv
// Activity window: counts cycles of one sampling window and accumulates busy.
// Latency: cnt reflects busy samples up to the previous edge; win_end is combinational.
// Backpressure: none. clear holds both counters at zero.
// Ports: clk, rst (sync, active-high), clear, busy -> win_end (last cycle), cnt (busy count).
module activity_window #(
  parameter int WIN_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           busy,
  output logic           win_end,
  output logic [WIN_W:0] cnt
);

  logic [WIN_W-1:0] win_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      win_cnt <= '0;
      cnt     <= '0;
    end else begin
      win_cnt <= win_cnt + 1'b1;
      // One extra bit holds the full-window count of 2^WIN_W without wrapping.
      cnt     <= cnt + {{WIN_W{1'b0}}, busy};
    end
  end

  assign win_end = &win_cnt;

endmodule

// File: rtl/dfs_governor.sv
// DFS governor: turns windowed busy counts into a 0..3 performance level and op_code.
// Latency: level/op_code/op_valid register on the edge leaving DECIDE or sampling force_valid.
// Backpressure: none. The consumer must take op_code whenever op_valid pulses.
// Ports: clk, rst, en, busy, force_valid, force_lvl -> op_code, op_valid, level, last_cnt.
module dfs_governor
  import dfs_pkg::*;
#(
  parameter int WIN_W = 6,
  parameter int UP_TH = 48,
  parameter int DN_TH = 16,
  parameter int DWELL = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           busy,
  input  logic           force_valid,
  input  logic [1:0]     force_lvl,
  output logic [5:0]     op_code,
  output logic           op_valid,
  output logic [1:0]     level,
  output logic [WIN_W:0] last_cnt
);

  localparam logic [WIN_W:0] UP_V    = UP_TH[WIN_W:0];
  localparam logic [WIN_W:0] DN_V    = DN_TH[WIN_W:0];
  localparam logic [3:0]     DWELL_V = DWELL[3:0];

  state_t         state;
  logic [3:0]     dwell;
  logic           win_end;
  logic [WIN_W:0] cnt;
  logic           force_hit;
  logic           clear;

  // A force is only honoured while enabled and outside IDLE.
  assign force_hit = en && force_valid && (state != IDLE);
  // Counters run only in MEASURE. DECIDE clears them so busy there is never counted.
  assign clear     = !en || force_hit || (state != MEASURE);

  activity_window #(.WIN_W(WIN_W)) u_win (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .busy    (busy),
    .win_end (win_end),
    .cnt     (cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dwell    <= '0;
      level    <= 2'd0;
      op_code  <= OP_L0;
      op_valid <= 1'b0;
      last_cnt <= '0;
    end else begin
      op_valid <= 1'b0;
      if (!en) begin
        state <= IDLE;
      end else if (force_hit) begin
        // Force beats a coincident window decision. The completed count is still recorded.
        if (state == DECIDE) last_cnt <= cnt;
        level    <= force_lvl;
        op_code  <= lvl_to_op(force_lvl);
        op_valid <= (force_lvl != level);
        dwell    <= DWELL_V;
        state    <= MEASURE;
      end else begin
        case (state)
          IDLE:    state <= MEASURE;
          MEASURE: if (win_end) state <= DECIDE;
          DECIDE: begin
            last_cnt <= cnt;
            state    <= MEASURE;
            if (dwell != 4'd0) begin
              dwell <= dwell - 4'd1;
            end else if (cnt >= UP_V && level != 2'd3) begin
              level    <= level + 2'd1;
              op_code  <= lvl_to_op(level + 2'd1);
              op_valid <= 1'b1;
              dwell    <= DWELL_V;
            end else if (cnt <= DN_V && level != 2'd0) begin
              level    <= level - 2'd1;
              op_code  <= lvl_to_op(level - 2'd1);
              op_valid <= 1'b1;
              dwell    <= DWELL_V;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dfs_governor.sv
// Testbench for dfs_governor: directed scenarios plus random traffic, every cycle
// compared against a window-level behavioural model.
// Ports: none (top-level bench).
module tb_dfs_governor;

  localparam int WIN   = 16;
  localparam int UP    = 12;
  localparam int DN    = 4;
  localparam int DW    = 2;

  logic       clk = 1'b0;
  logic       rst, en, busy, force_valid;
  logic [1:0] force_lvl;
  logic [5:0] op_code;
  logic       op_valid;
  logic [1:0] level;
  logic [4:0] last_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulse_q[$];

  // Reference model: position in window (-1 idle, 0..WIN-1 measuring, WIN deciding).
  int m_pos, m_sum, m_lvl, m_dwell, m_last, m_opv;
  int op_tab[4] = '{6'b000001, 6'b000010, 6'b101010, 6'b111111};

  dfs_governor #(.WIN_W(4), .UP_TH(UP), .DN_TH(DN), .DWELL(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .busy        (busy),
    .force_valid (force_valid),
    .force_lvl   (force_lvl),
    .op_code     (op_code),
    .op_valid    (op_valid),
    .level       (level),
    .last_cnt    (last_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic b, input logic e, input logic fv,
                            input logic [1:0] fl, input logic r);
    m_opv = 0;
    if (r) begin
      m_pos = -1; m_sum = 0; m_lvl = 0; m_dwell = 0; m_last = 0;
    end else if (!e) begin
      m_pos = -1; m_sum = 0;
    end else if (fv && m_pos != -1) begin
      if (m_pos == WIN) m_last = m_sum;
      m_opv   = (int'(fl) != m_lvl);
      m_lvl   = int'(fl);
      m_dwell = DW;
      m_pos   = 0; m_sum = 0;
    end else if (m_pos == -1) begin
      m_pos = 0; m_sum = 0;
    end else if (m_pos < WIN) begin
      m_sum += int'(b);
      m_pos++;
    end else begin
      m_last = m_sum;
      if (m_dwell > 0) m_dwell--;
      else if (m_sum >= UP && m_lvl < 3) begin m_lvl++; m_dwell = DW; m_opv = 1; end
      else if (m_sum <= DN && m_lvl > 0) begin m_lvl--; m_dwell = DW; m_opv = 1; end
      m_pos = 0; m_sum = 0;
    end
  endtask

  task automatic step(input logic b, input logic e, input logic fv,
                      input logic [1:0] fl, input logic r);
    busy = b; en = e; force_valid = fv; force_lvl = fl; rst = r;
    @(posedge clk);
    model_edge(b, e, fv, fl, r);
    #1;
    chk("op_code",  32'(op_code),  32'(op_tab[m_lvl]));
    chk("level",    32'(level),    32'(m_lvl));
    chk("op_valid", 32'(op_valid), 32'(m_opv));
    chk("last_cnt", 32'(last_cnt), 32'(m_last));
    if (op_valid) pulse_q.push_back(cyc);
    cyc++;
  endtask

  // Busy high for the first 'hi' cycles of each window.
  task automatic run_pattern(input int n, input int hi);
    for (int i = 0; i < n; i++) step(m_pos >= 0 && m_pos < hi, 1'b1, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic advance_to(input int target, input logic b);
    int guard = 0;
    while (m_pos != target && guard < 40) begin
      step(b, 1'b1, 1'b0, 2'd0, 1'b0);
      guard++;
    end
    chk("advance_bound", 32'(m_pos == target), 32'd1);
  endtask

  initial begin
    logic [1:0] keep_lvl;
    m_pos = -1; m_sum = 0; m_lvl = 0; m_dwell = 0; m_last = 0; m_opv = 0;

    // Reset then idle with en low.
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    pulse_q.delete();
    for (int i = 0; i < 100; i++) step($urandom_range(0, 1), 1'b0, 1'b0, 2'd0, 1'b0);
    chk("idle_no_pulse", 32'(pulse_q.size()), 32'd0);
    chk("idle_op", 32'(op_code), 32'b000001);

    // Ramp up with constant busy: three steps, 51 cycles apart, then saturate.
    pulse_q.delete();
    for (int i = 0; i < 3 * 51 + 80; i++) step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("ramp_pulses", 32'(pulse_q.size()), 32'd3);
    if (pulse_q.size() == 3) begin
      chk("ramp_gap1", 32'(pulse_q[1] - pulse_q[0]), 32'd51);
      chk("ramp_gap2", 32'(pulse_q[2] - pulse_q[1]), 32'd51);
    end
    chk("ramp_op", 32'(op_code), 32'b111111);

    // Hysteresis: half-busy windows hold level 3.
    run_pattern(5 * 17, 8);
    chk("hyst_last", 32'(last_cnt), 32'd8);
    chk("hyst_level", 32'(level), 32'd3);
    // Idle load walks back down to level 0.
    run_pattern(12 * 17, 0);
    chk("down_level", 32'(level), 32'd0);
    chk("down_op", 32'(op_code), 32'b000001);

    // Force mid-window.
    advance_to(5, 1'b0);
    step(1'b1, 1'b1, 1'b1, 2'd2, 1'b0);
    chk("force_op", 32'(op_code), 32'b101010);
    chk("force_vld", 32'(op_valid), 32'd1);
    run_pattern(7, 8);
    step(1'b0, 1'b1, 1'b1, 2'd2, 1'b0);
    chk("force_same_vld", 32'(op_valid), 32'd0);

    // Let dwell expire, then collide a force with DECIDE of a full-busy window.
    run_pattern(3 * 17 + 2, 8);
    advance_to(WIN, 1'b1);
    step(1'b1, 1'b1, 1'b1, 2'd1, 1'b0);
    chk("collide_level", 32'(level), 32'd1);

    // Disable mid-window: level held, window restarts later.
    advance_to(7, 1'b0);
    keep_lvl = level;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 2'd3, 1'b0);
    chk("dis_level", 32'(level), 32'(keep_lvl));
    run_pattern(40, 8);

    // Reset mid-window at level 3.
    step(1'b0, 1'b1, 1'b1, 2'd3, 1'b0);
    advance_to(9, 1'b1);
    step(1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_op", 32'(op_code), 32'b000001);
    chk("rst_vld", 32'(op_valid), 32'd0);
    chk("rst_last", 32'(last_cnt), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 60),
           ($urandom_range(0, 99) < 96),
           ($urandom_range(0, 99) < 3),
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 999) < 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
